sram_burst_ctrl: RTL and testbench

Parametrised asynchronous-SRAM controller and successor to the single-RAM, switch-driven test controller. It takes burst read/write commands over a valid/ready handshake and generates EN/OE/WE strobes with programmable setup, pulse, hold and read-access cycle counts. It auto-increments the address with wrap-around and streams write data in and read data out per beat. The block sits between the CPU/memory arbiter and the board RAM pins.

---
 rtl/sram_burst_ctrl_pkg.sv | 37 +++
 rtl/sram_burst_ctrl_if.sv | 38 +++
 rtl/sram_io_pad.sv | 42 ++++
 rtl/sram_burst_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_sram_burst_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_burst_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_burst_ctrl_pkg
// Description : Shared state encoding, strobe levels and helpers for the
//               asynchronous-SRAM burst controller.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_burst_ctrl_pkg;

  // Controller states; 3-bit encoding covers all eight states exactly.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_W_WAIT   = 3'd1,
    ST_W_SETUP  = 3'd2,
    ST_W_PULSE  = 3'd3,
    ST_W_HOLD   = 3'd4,
    ST_R_ACCESS = 3'd5,
    ST_TURN     = 3'd6,
    ST_FIN      = 3'd7
  } state_t;

  // SRAM strobes are active low.
  localparam logic c_ASSERT   = 1'b0;
  localparam logic c_DEASSERT = 1'b1;

  // Largest of four cycle counts; sizes the shared phase counter.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_burst_ctrl_if
// Description : Command / write-data / read-data handshake bundle between the
//               arbiter (master) and the SRAM burst controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_burst_ctrl_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] wdata;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              done;
  logic              busy;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wdata, wdata_valid,
    input  cmd_ready, wdata_ready, rdata, rdata_valid, done, busy
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wdata, wdata_valid,
    output cmd_ready, wdata_ready, rdata, rdata_valid, done, busy
  );

endinterface
`default_nettype wire

// File: rtl/sram_io_pad.sv
`default_nettype none
// ============================================================================
// Module      : sram_io_pad
// Description : Tristate driver for the SRAM data bus with a write-data
//               holding register and a read-data sample register.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_io_pad
  import sram_burst_ctrl_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  wire logic              CLK,
  input  wire logic              RST,
  input  wire logic              i_load,
  input  wire logic [DATA_W-1:0] i_wdata,
  input  wire logic              i_drive,
  input  wire logic              i_sample,
  output logic      [DATA_W-1:0] o_rdata,
  inout  wire       [DATA_W-1:0] io_data
);

  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  // Hold the accepted write beat so the bus stays stable through setup/pulse/hold.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_wdata <= '0;
    else if (i_load) r_wdata <= i_wdata;
  end

  // Capture the SRAM output on the last access cycle of a read beat.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_rdata <= '0;
    else if (i_sample) r_rdata <= io_data;
  end

  assign io_data = i_drive ? r_wdata : {DATA_W{1'bz}};
  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_burst_ctrl
// Description : Burst read/write controller for an asynchronous SRAM with
//               programmable setup / WE pulse / hold / read-access timing,
//               wrapping address increment and per-beat data streaming.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_burst_ctrl
  import sram_burst_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 16,
  parameter int LEN_W     = 8,
  parameter int SETUP_CYC = 2,
  parameter int WE_CYC    = 2,
  parameter int HOLD_CYC  = 1,
  parameter int RD_CYC    = 3
) (
  input  wire logic              CLK,
  input  wire logic              RST,
  sram_burst_ctrl_if.slave       bus,
  output logic                   Ram_EN,
  output logic                   Ram_OE,
  output logic                   Ram_WE,
  output logic      [ADDR_W-1:0] Ram_address,
  inout  wire       [DATA_W-1:0] Ram_data,
  output logic                   rdn,
  output logic                   wrn
);

  // The phase counter counts down from N-1 to 0, so it needs to hold max-1.
  localparam int c_PH_MAX = max4(SETUP_CYC, WE_CYC, HOLD_CYC, RD_CYC);
  localparam int c_PH_W   = (c_PH_MAX > 1) ? $clog2(c_PH_MAX) : 1;
  localparam logic [c_PH_W-1:0] c_LD_SETUP = c_PH_W'(SETUP_CYC - 1);
  localparam logic [c_PH_W-1:0] c_LD_WE    = c_PH_W'(WE_CYC - 1);
  localparam logic [c_PH_W-1:0] c_LD_HOLD  = c_PH_W'(HOLD_CYC - 1);
  localparam logic [c_PH_W-1:0] c_LD_RD    = c_PH_W'(RD_CYC - 1);

  state_t              r_state, w_state_nxt;
  logic [c_PH_W-1:0]   r_phase, w_phase_nxt;
  logic [LEN_W-1:0]    r_beats, w_beats_nxt;
  logic [ADDR_W-1:0]   r_addr,  w_addr_nxt;
  logic                r_write, w_write_nxt;
  logic                r_prev_vld;
  logic                r_prev_write;
  logic                r_rvalid;

  logic                w_en, w_oe, w_we, w_drive;
  logic                w_wr_take, w_rd_sample;
  logic                w_cmd_ready, w_wdata_ready, w_done;
  logic                w_last_beat;
  logic                w_turn;

  assign w_last_beat = (r_beats == LEN_W'(1));
  // A direction change since the last real burst needs a bus turnaround cycle.
  assign w_turn      = r_prev_vld && (r_prev_write != bus.cmd_write);

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Burst datapath: phase/beat counters, address, direction and history.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_phase      <= '0;
      r_beats      <= '0;
      r_addr       <= '0;
      r_write      <= 1'b0;
      r_prev_vld   <= 1'b0;
      r_prev_write <= 1'b0;
      r_rvalid     <= 1'b0;
    end else begin
      r_phase  <= w_phase_nxt;
      r_beats  <= w_beats_nxt;
      r_addr   <= w_addr_nxt;
      r_write  <= w_write_nxt;
      r_rvalid <= w_rd_sample;
      // Zero-length bursts never touch the bus, so they leave the history alone.
      if (r_state == ST_FIN && r_beats != '0) begin
        r_prev_vld   <= 1'b1;
        r_prev_write <= r_write;
      end
    end
  end

  // Next-state, counter reloads and strobe decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = r_phase;
    w_beats_nxt   = r_beats;
    w_addr_nxt    = r_addr;
    w_write_nxt   = r_write;
    w_en          = c_DEASSERT;
    w_oe          = c_DEASSERT;
    w_we          = c_DEASSERT;
    w_drive       = 1'b0;
    w_wr_take     = 1'b0;
    w_rd_sample   = 1'b0;
    w_cmd_ready   = 1'b0;
    w_wdata_ready = 1'b0;
    w_done        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          w_addr_nxt  = bus.cmd_addr;
          w_beats_nxt = bus.cmd_len;
          w_write_nxt = bus.cmd_write;
          w_phase_nxt = '0;
          if (bus.cmd_len == '0) begin
            w_state_nxt = ST_FIN;
          end else if (w_turn) begin
            w_state_nxt = ST_TURN;
          end else if (bus.cmd_write) begin
            w_state_nxt = ST_W_WAIT;
          end else begin
            w_state_nxt = ST_R_ACCESS;
            w_phase_nxt = c_LD_RD;
          end
        end
      end
      ST_TURN: begin
        if (r_write) begin
          w_state_nxt = ST_W_WAIT;
          w_phase_nxt = '0;
        end else begin
          w_state_nxt = ST_R_ACCESS;
          w_phase_nxt = c_LD_RD;
        end
      end
      ST_W_WAIT: begin
        w_en          = c_ASSERT;
        w_wdata_ready = bus.wdata_valid;
        if (bus.wdata_valid) begin
          w_wr_take   = 1'b1;
          w_state_nxt = ST_W_SETUP;
          w_phase_nxt = c_LD_SETUP;
        end
      end
      ST_W_SETUP: begin
        w_en    = c_ASSERT;
        w_drive = 1'b1;
        if (r_phase == '0) begin
          w_state_nxt = ST_W_PULSE;
          w_phase_nxt = c_LD_WE;
        end else begin
          w_phase_nxt = r_phase - c_PH_W'(1);
        end
      end
      ST_W_PULSE: begin
        w_en    = c_ASSERT;
        w_we    = c_ASSERT;
        w_drive = 1'b1;
        if (r_phase == '0) begin
          w_state_nxt = ST_W_HOLD;
          w_phase_nxt = c_LD_HOLD;
        end else begin
          w_phase_nxt = r_phase - c_PH_W'(1);
        end
      end
      ST_W_HOLD: begin
        w_en    = c_ASSERT;
        w_drive = 1'b1;
        if (r_phase == '0) begin
          if (w_last_beat) begin
            w_state_nxt = ST_FIN;
          end else begin
            w_beats_nxt = r_beats - LEN_W'(1);
            w_addr_nxt  = r_addr + ADDR_W'(1);
            w_state_nxt = ST_W_WAIT;
          end
          w_phase_nxt = '0;
        end else begin
          w_phase_nxt = r_phase - c_PH_W'(1);
        end
      end
      ST_R_ACCESS: begin
        w_en = c_ASSERT;
        w_oe = c_ASSERT;
        if (r_phase == '0) begin
          w_rd_sample = 1'b1;
          if (w_last_beat) begin
            w_state_nxt = ST_FIN;
            w_phase_nxt = '0;
          end else begin
            // Stay in the access state with OE low; only the address moves.
            w_beats_nxt = r_beats - LEN_W'(1);
            w_addr_nxt  = r_addr + ADDR_W'(1);
            w_phase_nxt = c_LD_RD;
          end
        end else begin
          w_phase_nxt = r_phase - c_PH_W'(1);
        end
      end
      ST_FIN: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  sram_io_pad #(
    .DATA_W (DATA_W)
  ) u_pad (
    .CLK      (CLK),
    .RST      (RST),
    .i_load   (w_wr_take),
    .i_wdata  (bus.wdata),
    .i_drive  (w_drive),
    .i_sample (w_rd_sample),
    .o_rdata  (bus.rdata),
    .io_data  (Ram_data)
  );

  assign Ram_EN          = w_en;
  assign Ram_OE          = w_oe;
  assign Ram_WE          = w_we;
  assign Ram_address     = r_addr;
  assign bus.cmd_ready   = w_cmd_ready;
  assign bus.wdata_ready = w_wdata_ready;
  assign bus.rdata_valid = r_rvalid;
  assign bus.done        = w_done;
  assign bus.busy        = (r_state != ST_IDLE);
  assign rdn             = 1'b1;
  assign wrn             = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_sram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_burst_ctrl
// Description : Self-checking bench for sram_burst_ctrl with an SRAM device
//               model and a burst-level reference memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_burst_ctrl;

  localparam int ADDR_W    = 18;
  localparam int DATA_W    = 16;
  localparam int LEN_W     = 8;
  localparam int SETUP_CYC = 2;
  localparam int WE_CYC    = 2;
  localparam int HOLD_CYC  = 1;
  localparam int RD_CYC    = 3;
  localparam int MEM_N     = 1 << ADDR_W;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #10 CLK = ~CLK;

  sram_burst_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  logic              Ram_EN, Ram_OE, Ram_WE, rdn, wrn;
  logic [ADDR_W-1:0] Ram_address;
  wire  [DATA_W-1:0] Ram_data;

  sram_burst_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .SETUP_CYC(SETUP_CYC),
    .WE_CYC(WE_CYC), .HOLD_CYC(HOLD_CYC), .RD_CYC(RD_CYC)
  ) dut (
    .CLK(CLK), .RST(RST), .bus(bus), .Ram_EN(Ram_EN), .Ram_OE(Ram_OE),
    .Ram_WE(Ram_WE), .Ram_address(Ram_address), .Ram_data(Ram_data),
    .rdn(rdn), .wrn(wrn)
  );

  // SRAM device: drives the bus while selected with OE low, writes while WE low.
  logic [DATA_W-1:0] dev_mem [MEM_N];
  assign Ram_data = (!Ram_EN && !Ram_OE) ? dev_mem[Ram_address] : {DATA_W{1'bz}};
  always @(posedge CLK) if (RST && !Ram_EN && !Ram_WE) dev_mem[Ram_address] <= Ram_data;

  // Reference memory: what every completed write burst should have left behind.
  logic [DATA_W-1:0] ref_mem [int];
  function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return '0;
  endfunction

  int n_total = 0;
  int n_bad   = 0;
  int m_we_falls = 0, m_oe_cyc = 0, m_rv = 0, m_done = 0;
  bit prev_vld = 1'b0, prev_wr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Cycle monitor: a beat's write timeline is counted from its data handshake.
  task automatic monitor();
    logic [ADDR_W-1:0] base = '0;
    logic [ADDR_W-1:0] hs_a = '0;
    logic [DATA_W-1:0] hs_d = '0;
    int  wbeat = 0, oe_n = 0, rv_n = 0, hs_n = 0;
    bit  hs_on = 1'b0;
    logic prev_we = 1'b1;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        hs_on = 1'b0; prev_we = 1'b1;
        continue;
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        base = bus.cmd_addr; wbeat = 0; oe_n = 0; rv_n = 0;
      end
      if (hs_on) begin
        hs_n++;
        if (hs_n > SETUP_CYC + WE_CYC + HOLD_CYC) hs_on = 1'b0;
      end
      if (hs_on) begin
        chk("wr_addr", Ram_address, hs_a);
        chk("wr_data", Ram_data, hs_d);
        chk("wr_en", Ram_EN, 1'b0);
        chk("we_shape", Ram_WE, (hs_n > SETUP_CYC && hs_n <= SETUP_CYC + WE_CYC) ? 1'b0 : 1'b1);
      end else begin
        chk("we_idle", Ram_WE, 1'b1);
      end
      if (prev_we && !Ram_WE) m_we_falls++;
      prev_we = Ram_WE;
      if (bus.wdata_valid && bus.wdata_ready) begin
        hs_on = 1'b1; hs_n = 0; hs_d = bus.wdata;
        hs_a = ADDR_W'(base + wbeat); wbeat++;
      end
      if (!Ram_OE) begin
        chk("oe_we", Ram_WE, 1'b1);
        chk("rd_addr", Ram_address, ADDR_W'(base + oe_n / RD_CYC));
        oe_n++; m_oe_cyc++;
      end
      if (bus.rdata_valid) begin
        chk("rdata", bus.rdata, ref_rd(ADDR_W'(base + rv_n)));
        rv_n++; m_rv++;
      end
      if (bus.done) m_done++;
    end
  endtask

  // One burst; dstart >= 0 gives data dstart, dstart+1, ... else random data.
  task automatic burst(input bit wr, input logic [ADDR_W-1:0] a, input int n,
                       input int dstart, input int gap_max, input int stall_beat,
                       input int stall_cyc);
    logic [DATA_W-1:0] d [$];
    int  falls0, oe0, rv0, done0, cyc, first_en, beat, gap, stall_left, budget;
    bit  turn, seen_done, hs, stalling, got_rdy;
    for (int i = 0; i < n; i++) d.push_back(dstart >= 0 ? DATA_W'(dstart + i) : DATA_W'($urandom));
    turn = (n != 0) && prev_vld && (prev_wr != wr);
    falls0 = m_we_falls; oe0 = m_oe_cyc; rv0 = m_rv; done0 = m_done;
    @(posedge CLK); #1;
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = a; bus.cmd_len = LEN_W'(n);
    got_rdy = 1'b0;
    for (int k = 0; k < 40 && !got_rdy; k++) begin
      @(negedge CLK);
      got_rdy = bus.cmd_ready;
      @(posedge CLK); #1;
    end
    bus.cmd_valid = 1'b0;
    if (!got_rdy) begin
      chk("cmd_accept_timeout", 32'd0, 32'd1);
      return;
    end
    beat = 0; cyc = 0; first_en = -1; seen_done = 1'b0; stall_left = 0;
    gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
    budget = 40 + n * (8 + 2 * gap_max) + stall_cyc;
    while (!seen_done && cyc < budget) begin
      stalling = wr && beat < n && beat == stall_beat && stall_left > 0;
      if (wr && beat < n && !stalling && gap == 0) begin
        bus.wdata_valid = 1'b1; bus.wdata = d[beat];
      end else begin
        bus.wdata_valid = 1'b0;
      end
      @(negedge CLK); cyc++;
      if (cyc == 1) begin
        chk("busy_after_accept", bus.busy, 1'b1);
        chk("cmd_ready_busy", bus.cmd_ready, 1'b0);
      end
      if (first_en < 0 && !Ram_EN) first_en = cyc;
      if (stalling && (stall_cyc - stall_left) >= SETUP_CYC + WE_CYC + HOLD_CYC) begin
        chk("stall_we", Ram_WE, 1'b1);
        chk("stall_en", Ram_EN, 1'b0);
      end
      hs = bus.wdata_valid && bus.wdata_ready;
      if (bus.done) seen_done = 1'b1;
      @(posedge CLK); #1;
      if (hs) begin
        beat++;
        gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
        if (beat == stall_beat) stall_left = stall_cyc;
      end else if (stalling) begin
        stall_left--;
      end else if (gap > 0) begin
        gap--;
      end
    end
    bus.wdata_valid = 1'b0;
    chk("done_seen", seen_done, 1'b1);
    if (n == 0) begin
      chk("len0_done_cyc", cyc, 32'd1);
      chk("len0_no_strobe", first_en, 32'hFFFF_FFFF);
    end else begin
      chk("first_strobe_cyc", first_en, turn ? 32'd2 : 32'd1);
    end
    chk("we_pulses", m_we_falls - falls0, wr ? n : 0);
    chk("oe_cycles", m_oe_cyc - oe0, wr ? 0 : n * RD_CYC);
    chk("rd_beats", m_rv - rv0, wr ? 0 : n);
    @(negedge CLK);
    chk("done_once", m_done - done0, 32'd1);
    chk("idle_busy", bus.busy, 1'b0);
    chk("idle_cmd_ready", bus.cmd_ready, 1'b1);
    if (wr) for (int i = 0; i < n; i++) ref_mem[int'(ADDR_W'(a + i))] = d[i];
    if (n != 0) begin prev_vld = 1'b1; prev_wr = wr; end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_en"}, Ram_EN, 1'b1);
    chk({tag, "_oe"}, Ram_OE, 1'b1);
    chk({tag, "_we"}, Ram_WE, 1'b1);
    chk({tag, "_addr"}, Ram_address, '0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_done"}, bus.done, 1'b0);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1'b1);
    chk({tag, "_wdata_ready"}, bus.wdata_ready, 1'b0);
    chk({tag, "_rvalid"}, bus.rdata_valid, 1'b0);
  endtask

  initial begin
    int done0;
    bit found;
    for (int i = 0; i < MEM_N; i++) dev_mem[i] = '0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wdata = '0; bus.wdata_valid = 1'b0;
    fork monitor(); join_none
    repeat (3) @(negedge CLK);
    chk_reset_outputs("rst");
    chk("rst_rdata", bus.rdata, '0);
    chk("rdn", rdn, 1'b1);
    chk("wrn", wrn, 1'b1);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    burst(1'b1, 18'h00100, 10, 5, 0, -1, 0);
    burst(1'b0, 18'h00100, 10, 0, 0, -1, 0);
    burst(1'b1, 18'h3FFFE, 3, -1, 0, -1, 0);
    burst(1'b0, 18'h3FFFE, 3, 0, 0, -1, 0);
    burst(1'b1, 18'h00200, 4, 32'h0A00, 0, 1, 10);
    burst(1'b0, 18'h00200, 4, 0, 0, -1, 0);
    burst(1'b1, 18'h00300, 0, 0, 0, -1, 0);

    for (int r = 0; r < 10; r++) begin
      logic [ADDR_W-1:0] ra;
      ra = ($urandom_range(0, 1) == 1) ? ADDR_W'(18'h3FFF8 + $urandom_range(0, 7))
                                       : ADDR_W'(18'h00100 + $urandom_range(0, 15));
      burst(1'($urandom_range(0, 1)), ra, $urandom_range(0, 6), -1, 2, -1, 0);
    end

    // Reset in the middle of a WE pulse.
    done0 = m_done;
    @(posedge CLK); #1;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 18'h02000; bus.cmd_len = 8'd3;
    @(posedge CLK); #1;
    bus.cmd_valid = 1'b0; bus.wdata = 16'hABCD; bus.wdata_valid = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge CLK);
      found = !Ram_WE;
    end
    chk("rst_reached_pulse", found, 1'b1);
    #2 RST = 1'b0;
    bus.wdata_valid = 1'b0;
    #1;
    chk_reset_outputs("abort");
    repeat (2) @(negedge CLK);
    chk("abort_hold_done", bus.done, 1'b0);
    RST = 1'b1;
    prev_vld = 1'b0;
    repeat (4) @(negedge CLK);
    chk("abort_no_done", m_done - done0, 32'd0);
    chk("abort_idle_busy", bus.busy, 1'b0);

    burst(1'b1, 18'h00400, 0, 0, 0, -1, 0);
    burst(1'b0, 18'h00100, 2, 0, 0, -1, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
